// File: rtl/sram_controller.sv
// Sequences one 32-bit MEM-stage load/store onto a 16-bit async SRAM as two half accesses.
// Freezes the pipeline (ready=0) for 2*WAIT_CYCLES+1 cycles per access; inputs are sampled only in IDLE.
module sram_controller #(
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = 1024,
   parameter int SRAM_ADDR_W = 18
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_r_en,
   input  logic                   mem_w_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n
);

   localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int WORD_W = SRAM_ADDR_W - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   is_write_q, is_write_d;
   logic [WORD_W-1:0]      word_q, word_d;
   logic [15:0]            wdata_hi_q, wdata_hi_d;
   logic [15:0]            rdata_lo_q, rdata_lo_d;
   logic [31:0]            read_data_q, read_data_d;
   logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [15:0]            dq_out_q, dq_out_d;
   logic                   we_n_q, we_n_d;
   logic                   oe_q, oe_d;

   logic                   req;
   logic                   phase_end;
   logic [31:0]            offset;
   logic [WORD_W-1:0]      req_word;
   logic                   unused_addr_bits;

   assign req       = mem_r_en | mem_w_en;
   assign offset    = address - 32'(BASE_ADDR);
   // Byte offset -> 32-bit word index; the two lowest address bits and anything above the SRAM are dropped.
   assign req_word  = offset[WORD_W+1:2];
   assign unused_addr_bits = ^{offset[31:WORD_W+2], offset[1:0]};
   assign phase_end = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      is_write_d  = is_write_q;
      word_d      = word_q;
      wdata_hi_d  = wdata_hi_q;
      rdata_lo_d  = rdata_lo_q;
      read_data_d = read_data_q;
      sram_addr_d = sram_addr_q;
      dq_out_d    = dq_out_q;
      we_n_d      = we_n_q;
      oe_d        = oe_q;
      ready       = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready = ~req;
            if (req) begin
               state_d     = S_LO;
               is_write_d  = mem_w_en;
               word_d      = req_word;
               wdata_hi_d  = write_data[31:16];
               sram_addr_d = {req_word, 1'b0};
               if (mem_w_en) begin
                  dq_out_d = write_data[15:0];
               end
               we_n_d = ~mem_w_en;
               oe_d   = mem_w_en;
            end
         end
         S_LO: begin
            cnt_d = cnt_q + 1'b1;
            if (phase_end) begin
               cnt_d       = '0;
               state_d     = S_HI;
               sram_addr_d = {word_q, 1'b1};
               if (is_write_q) begin
                  dq_out_d = wdata_hi_q;
               end else begin
                  rdata_lo_d = sram_dq_in;
               end
            end
         end
         S_HI: begin
            cnt_d = cnt_q + 1'b1;
            if (phase_end) begin
               cnt_d   = '0;
               state_d = S_DONE;
               we_n_d  = 1'b1;
               oe_d    = 1'b0;
               // The high half is still on the bus here, so it goes straight into the result.
               if (!is_write_q) begin
                  read_data_d = {sram_dq_in, rdata_lo_q};
               end
            end
         end
         S_DONE: begin
            ready   = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (rst) begin
         ready = ~req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         is_write_q  <= 1'b0;
         word_q      <= '0;
         wdata_hi_q  <= '0;
         rdata_lo_q  <= '0;
         read_data_q <= '0;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
         we_n_q      <= 1'b1;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_write_q  <= is_write_d;
         word_q      <= word_d;
         wdata_hi_q  <= wdata_hi_d;
         rdata_lo_q  <= rdata_lo_d;
         read_data_q <= read_data_d;
         sram_addr_q <= sram_addr_d;
         dq_out_q    <= dq_out_d;
         we_n_q      <= we_n_d;
         oe_q        <= oe_d;
      end
   end

   assign read_data   = read_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_we_n   = we_n_q;
   assign sram_dq_oe  = oe_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed and random loads/stores against a word-level memory model.
module tb_sram_controller;

   localparam int W    = 2;
   localparam int BASE = 1024;
   localparam int AW   = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_r_en, mem_w_en;
   logic [31:0]   address, write_data;
   logic [31:0]   read_data;
   logic          ready;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out, sram_dq_in;
   logic          sram_dq_oe, sram_we_n;

   logic [15:0]   sram_mem [0:(1<<AW)-1];
   logic [31:0]   ref_word [int];
   int            written[$];
   logic [31:0]   last_read;
   int            checks = 0;
   int            errors = 0;

   sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM: reads follow the address, writes land while we_n is low.
   assign sram_dq_in = sram_mem[sram_addr];
   always @(posedge clk) begin
      if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int word_of(input logic [31:0] a);
      return int'(((a - 32'(BASE)) >> 2) % 32'(1 << (AW - 1)));
   endfunction

   // One pipeline access: enables held until ready rises, then the pipeline advances.
   task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
      int          idx;
      int          n;
      int          hi;
      logic [31:0] exp_rd;
      logic [31:0] half;
      idx    = word_of(a);
      half   = 32'(idx * 2);
      exp_rd = last_read;
      if (w) begin
         ref_word[idx] = d;
         written.push_back(idx);
      end else if (r) begin
         exp_rd = ref_word.exists(idx) ? ref_word[idx] : 32'h0;
      end
      mem_r_en   = r;
      mem_w_en   = w;
      address    = a;
      write_data = d;
      for (n = 0; n < 2 * W + 10; n++) begin
         @(negedge clk);
         if (ready) break;
         if (n == 0) begin
            chk("req_we_n", sram_we_n, 1);
            chk("req_oe", sram_dq_oe, 0);
         end else begin
            hi = (n > W) ? 1 : 0;
            chk("bus_addr", sram_addr, half + hi);
            chk("bus_we_n", sram_we_n, w ? 0 : 1);
            chk("bus_oe", sram_dq_oe, w ? 1 : 0);
            if (w) chk("bus_dq", sram_dq_out, (hi != 0) ? d[31:16] : d[15:0]);
         end
      end
      chk("freeze_cycles", n, 2 * W + 1);
      chk("read_data", read_data, exp_rd);
      chk("done_we_n", sram_we_n, 1);
      chk("done_oe", sram_dq_oe, 0);
      last_read = exp_rd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         chk("idle_ready", ready, 1);
         chk("idle_hold_rd", read_data, last_read);
         chk("idle_we_n", sram_we_n, 1);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int          idx;
      bit          wr;
      logic [31:0] a;

      rst        = 1'b1;
      mem_r_en   = 1'b0;
      mem_w_en   = 1'b0;
      address    = 32'h0;
      write_data = 32'h0;
      last_read  = 32'h0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_oe", sram_dq_oe, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_dq", sram_dq_out, 0);
      chk("rst_rd", read_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      access(0, 1, 32'd1024, 32'hDEADBEEF);
      idle(1);
      chk("mem0", sram_mem[0], 32'h0000BEEF);
      chk("mem1", sram_mem[1], 32'h0000DEAD);
      access(1, 0, 32'd1024, 32'h0);
      idle(1);

      access(0, 1, 32'd1028, 32'hA5A55A5A);
      access(1, 0, 32'd1031, 32'h0);
      idle(1);

      access(1, 0, 32'd1024, 32'h0);
      access(1, 0, 32'd1028, 32'h0);
      idle(2);

      access(1, 1, 32'd1036, 32'h12345678);
      idle(1);
      chk("both_mem6", sram_mem[6], 32'h00005678);
      chk("both_mem7", sram_mem[7], 32'h00001234);

      access(0, 1, 32'd0, 32'hCAFEF00D);
      access(1, 0, 32'd2, 32'h0);
      idle(1);

      repeat (40) begin
         wr = ($urandom_range(0, 2) == 0);
         if (wr) begin
            idx = $urandom_range(0, 63);
            a   = 32'(BASE + idx * 4 + $urandom_range(0, 3));
            access(bit'($urandom_range(0, 1)), 1, a, $urandom);
         end else begin
            idx = written[$urandom_range(0, written.size() - 1)];
            a   = 32'(BASE + idx * 4 + $urandom_range(0, 3));
            access(1, 0, a, $urandom);
         end
         idle($urandom_range(0, 2));
      end

      // Reset lands in the first HI cycle of a write.
      mem_r_en   = 1'b0;
      mem_w_en   = 1'b1;
      address    = 32'(BASE + 400);
      write_data = 32'h0BADF00D;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b1;
      mem_w_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_we_n", sram_we_n, 1);
      chk("mid_rst_oe", sram_dq_oe, 0);
      chk("mid_rst_rd", read_data, 0);
      chk("mid_rst_addr", sram_addr, 0);
      chk("mid_rst_dq", sram_dq_out, 0);
      chk("mid_rst_lo_half", sram_mem[200], 32'h0000F00D);
      ref_word.delete(100);
      last_read = 32'h0;
      @(posedge clk);
      #1;
      access(1, 0, 32'd1024, 32'h0);
      idle(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the MEM-stage data memory access onto an external 16-bit asynchronous SRAM.
- Splits each 32-bit load/store into two 16-bit half accesses (low half, then high half) with programmable wait states.
- Drops `ready` so the pipeline freezes while an access is in flight.
- Sits between the MEM stage (`mem_r_en`, `mem_w_en`, ALU address, store data) and the SRAM pins; the loaded word goes to the MEM/WB register.

Parameters:
- WAIT_CYCLES, 2, cycles each half access is held on the SRAM bus (≥1).
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_ADDR_W, 18, SRAM address width in 16-bit half-words.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- mem_r_en  input  1  load request from MEM stage
- mem_w_en  input  1  store request from MEM stage
- address  input  32  byte address (ALU result)
- write_data  input  32  store data (Val_Rm)
- read_data  output  32  loaded word, registered
- ready  output  1  0 = freeze pipeline; combinational
- sram_addr  output  SRAM_ADDR_W  SRAM half-word address, registered
- sram_dq_out  output  16  data driven to SRAM, registered
- sram_dq_in  input  16  data returned from SRAM
- sram_dq_oe  output  1  1 = controller drives DQ bus (writes only)
- sram_we_n  output  1  SRAM write enable, active low

Behaviour:
- Address mapping:
  - word_addr = (address − BASE_ADDR) >> 2, truncated to SRAM_ADDR_W−1 bits.
  - Low half at {word_addr,0}, high half at {word_addr,1}.
  - address[1:0] ignored; no range check.
- FSM states:
  - IDLE → LO when mem_r_en | mem_w_en.
  - LO → HI after WAIT_CYCLES cycles.
  - HI → DONE after WAIT_CYCLES cycles.
  - DONE → IDLE unconditionally.
- Operation latching: captured in IDLE on the accepting edge (is_write = mem_w_en, address, write_data).
  - Both enables high → treated as write.
  - Inputs ignored in LO/HI/DONE.
- Wait counter: resets to 0 on every phase entry, increments each cycle, and ends the phase when count == WAIT_CYCLES−1.
- ready:
  - 1 in IDLE with no request, and 1 in DONE.
  - 0 in IDLE with a request, and 0 in LO and HI.
  - Total freeze = 2·WAIT_CYCLES+1 cycles from first request cycle (5 for default).
- DONE:
  - Pipeline advances.
  - Enables still high from the same instruction are ignored.
  - A new request is accepted only from IDLE (next cycle), so back-to-back accesses have one ready=1 gap cycle between them.
- LO phase bus:
  - sram_addr = {word_addr,0}.
  - Write: sram_dq_out = wdata[15:0], sram_dq_oe = 1, sram_we_n = 0 for all WAIT_CYCLES cycles.
  - Read: sram_dq_oe = 0, sram_we_n = 1; rdata_lo latches sram_dq_in on the last LO cycle.
- HI phase bus: same as LO with {word_addr,1}, wdata[31:16], and rdata_hi.
- read_data:
  - Updated to {rdata_hi, rdata_lo} on entry to DONE for reads only.
  - Holds value otherwise, including across writes.
- IDLE/DONE bus state: sram_we_n = 1, sram_dq_oe = 0; sram_addr and sram_dq_out hold last value.
- Reset (any state, incl. mid-access):
  - Next state IDLE; counter 0.
  - sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0, read_data = 0, latched operation cleared.
  - ready = 1 if no request is present in that cycle.
  - An interrupted write may leave one half written; not repaired.

Test Plan:
- Write 0xDEADBEEF to address 1024 (W=2) → sram_addr 0 gets 0xBEEF, addr 1 gets 0xDEAD; we_n low 2 cycles each; ready low exactly 5 cycles, high in 6th.
- Read address 1024 with SRAM model from previous test → read_data = 0xDEADBEEF in DONE cycle; oe = 0, we_n = 1 throughout.
- Address 1028 / 1031 → sram_addr 2 then 3 for both; low bits ignored.
- Back-to-back: mem_r_en held high for two consecutive loads → second access starts the cycle after DONE; one ready=1 gap; no request lost or duplicated.
- mem_r_en & mem_w_en both high, write_data 0x12345678 → write performed; read_data unchanged.
- rst asserted during HI of a write → next cycle IDLE, we_n = 1, oe = 0, read_data = 0, ready = 1 with enables low; fresh read afterwards completes normally in 5 cycles.
